// File: rtl/vertex_write_buffer.sv
// rtl/vertex_write_buffer.sv - circular FIFO between matrix datapath and memory write port
module vertex_write_buffer #(
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [ADDR_WIDTH-1:0]     in_addr,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      stall,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [ADDR_WIDTH-1:0]     wr_addr,
    output logic [WIDTH-1:0]          wr_data,
    input  logic                      drain,
    output logic                      drain_done,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    input  logic                      clear_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        stRun,
        stDrain
    } drainState_e;

    logic [ADDR_WIDTH-1:0] addrMem [DEPTH];
    logic [WIDTH-1:0]      dataMem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wrPtr;
    logic [PTR_W:0] rdPtr;
    logic           isEmpty;
    logic           isFull;
    logic           doPush;
    logic           doPop;
    drainState_e    drainState;

    assign isEmpty  = (wrPtr == rdPtr);
    assign isFull   = (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]) && (wrPtr[PTR_W] != rdPtr[PTR_W]);
    // Full is judged before the edge, so a same-cycle pop cannot make room for the beat.
    assign doPush   = in_valid && !isFull;
    assign doPop    = !isEmpty && wr_ready;

    assign count    = wrPtr - rdPtr;
    assign stall    = (count >= CNT_W'(DEPTH - STALL_MARGIN));
    assign wr_valid = !isEmpty;
    assign wr_addr  = addrMem[rdPtr[PTR_W-1:0]];
    assign wr_data  = dataMem[rdPtr[PTR_W-1:0]];

    // Storage array; contents need no reset because wr_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (doPush) begin
            addrMem[wrPtr[PTR_W-1:0]] <= in_addr;
            dataMem[wrPtr[PTR_W-1:0]] <= in_data;
        end
    end

    // Read/write pointer advance; power-of-two depth lets the index wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + CNT_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + CNT_W'(1);
            end
        end
    end

    // Sticky overflow on a dropped beat; a drop in the same cycle as clear_err keeps it set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (in_valid && isFull) begin
            overflow <= 1'b1;
        end else if (clear_err) begin
            overflow <= 1'b0;
        end
    end

    // Drain tracker: after a job is issued, pulse drain_done once the buffer is empty and idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drainState <= stRun;
            drain_done <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            case (drainState)
                stRun: begin
                    if (drain) begin
                        drainState <= stDrain;
                    end
                end
                stDrain: begin
                    if ((count == '0) && !doPush) begin
                        drain_done <= 1'b1;
                        drainState <= stRun;
                    end
                end
                default: drainState <= stRun;
            endcase
        end
    end

endmodule
